// File: rtl/dac_sweep_ctrl.sv
// ============================================================================
// Module      : dac_sweep_ctrl
// Description : Frequency-sweep sequencer that steps a DDS phase increment
//               from f_start toward f_stop, holding each step for a dwell time.
//               Optional inter-step silent gap compiled in by DAC_SWEEP_GAP_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dac_sweep_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic [7:0]  f_start,
   input  logic [7:0]  f_step,
   input  logic [7:0]  f_stop,
   input  logic [15:0] dwell,
   input  logic [7:0]  gap_len,
   output logic [7:0]  phase_inc,
   output logic        tone_en,
   output logic        step_strobe,
   output logic [7:0]  step_idx,
   output logic        busy,
   output logic        done,
   output logic        cfg_err
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SETTLE = 3'd1;
   localparam logic [2:0] RUN    = 3'd2;
   localparam logic [2:0] DONE   = 3'd4;
`ifdef DAC_SWEEP_GAP_EN
   localparam logic [2:0] GAP    = 3'd3;
`endif

   logic [2:0]  state_q,    state_d;
   logic        settle_q,   settle_d;
   logic [15:0] dwell_cnt_q, dwell_cnt_d;
   logic [7:0]  phase_q,    phase_d;
   logic [7:0]  idx_q,      idx_d;
   logic        strobe_q,   strobe_d;
   logic        cfg_err_q,  cfg_err_d;
   logic [7:0]  f_step_q,   f_step_d;
   logic [7:0]  f_stop_q,   f_stop_d;
   logic [15:0] dwell_q,    dwell_d;

   logic [15:0] dwell_last;
   logic        dwell_tc;
   logic [8:0]  next_sum;

`ifdef DAC_SWEEP_GAP_EN
   logic [7:0]  gap_cnt_q,  gap_cnt_d;
   logic [7:0]  gap_len_q,  gap_len_d;
   logic [7:0]  gap_last;
   assign gap_last = (gap_len_q == 8'd0) ? 8'd0 : gap_len_q - 8'd1;
`else
   logic unused_gap_len;
   assign unused_gap_len = ^gap_len;
`endif

   // dwell=0 behaves as a one-cycle dwell
   assign dwell_last = (dwell_q == 16'd0) ? 16'd0 : dwell_q - 16'd1;
   assign dwell_tc   = (dwell_cnt_q == dwell_last);
   assign next_sum   = {1'b0, phase_q} + {1'b0, f_step_q};

   always_comb begin
      state_d     = state_q;
      settle_d    = settle_q;
      dwell_cnt_d = dwell_cnt_q;
      phase_d     = phase_q;
      idx_d       = idx_q;
      strobe_d    = 1'b0;
      cfg_err_d   = 1'b0;
      f_step_d    = f_step_q;
      f_stop_d    = f_stop_q;
      dwell_d     = dwell_q;
`ifdef DAC_SWEEP_GAP_EN
      gap_cnt_d   = gap_cnt_q;
      gap_len_d   = gap_len_q;
`endif
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               if ((f_step == 8'd0) || (f_start > f_stop)) begin
                  cfg_err_d = 1'b1;
               end else begin
                  f_step_d = f_step;
                  f_stop_d = f_stop;
                  dwell_d  = dwell;
`ifdef DAC_SWEEP_GAP_EN
                  gap_len_d = gap_len;
`endif
                  phase_d  = f_start;
                  idx_d    = 8'd0;
                  settle_d = 1'b0;
                  state_d  = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (stop) begin
               phase_d = 8'd0;
               state_d = DONE;
            end else if (settle_q) begin
               dwell_cnt_d = 16'd0;
               state_d     = RUN;
            end else begin
               settle_d = 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               phase_d = 8'd0;
               state_d = DONE;
            end else if (dwell_tc) begin
               // 9-bit compare so an overflowing step ends the sweep instead of wrapping
               if (next_sum > {1'b0, f_stop_q}) begin
                  phase_d = 8'd0;
                  state_d = DONE;
               end else begin
                  phase_d     = next_sum[7:0];
                  strobe_d    = 1'b1;
                  idx_d       = (idx_q == 8'hFF) ? idx_q : idx_q + 8'd1;
                  dwell_cnt_d = 16'd0;
`ifdef DAC_SWEEP_GAP_EN
                  gap_cnt_d   = 8'd0;
                  state_d     = GAP;
`endif
               end
            end else begin
               dwell_cnt_d = dwell_cnt_q + 16'd1;
            end
         end
`ifdef DAC_SWEEP_GAP_EN
         GAP: begin
            if (stop) begin
               phase_d = 8'd0;
               state_d = DONE;
            end else if (gap_cnt_q == gap_last) begin
               dwell_cnt_d = 16'd0;
               state_d     = RUN;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
`endif
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         settle_q    <= 1'b0;
         dwell_cnt_q <= 16'd0;
         phase_q     <= 8'd0;
         idx_q       <= 8'd0;
         strobe_q    <= 1'b0;
         cfg_err_q   <= 1'b0;
         f_step_q    <= 8'd0;
         f_stop_q    <= 8'd0;
         dwell_q     <= 16'd0;
`ifdef DAC_SWEEP_GAP_EN
         gap_cnt_q   <= 8'd0;
         gap_len_q   <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         settle_q    <= settle_d;
         dwell_cnt_q <= dwell_cnt_d;
         phase_q     <= phase_d;
         idx_q       <= idx_d;
         strobe_q    <= strobe_d;
         cfg_err_q   <= cfg_err_d;
         f_step_q    <= f_step_d;
         f_stop_q    <= f_stop_d;
         dwell_q     <= dwell_d;
`ifdef DAC_SWEEP_GAP_EN
         gap_cnt_q   <= gap_cnt_d;
         gap_len_q   <= gap_len_d;
`endif
      end
   end

   assign phase_inc   = phase_q;
   assign tone_en     = (state_q == RUN);
   assign step_strobe = strobe_q;
   assign step_idx    = idx_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign cfg_err     = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dac_sweep_ctrl.sv
// ============================================================================
// Module      : tb_dac_sweep_ctrl
// Description : Scoreboard bench for dac_sweep_ctrl; directed sweeps push
//               expected pulse events, a negedge monitor pops and compares.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_dac_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [7:0]  f_start = 8'd0;
   logic [7:0]  f_step = 8'd0;
   logic [7:0]  f_stop = 8'd0;
   logic [15:0] dwell = 16'd0;
   logic [7:0]  gap_len = 8'd0;
   logic [7:0]  phase_inc;
   logic        tone_en;
   logic        step_strobe;
   logic [7:0]  step_idx;
   logic        busy;
   logic        done;
   logic        cfg_err;

   dac_sweep_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .f_start     (f_start),
      .f_step      (f_step),
      .f_stop      (f_stop),
      .dwell       (dwell),
      .gap_len     (gap_len),
      .phase_inc   (phase_inc),
      .tone_en     (tone_en),
      .step_strobe (step_strobe),
      .step_idx    (step_idx),
      .busy        (busy),
      .done        (done),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   localparam logic [2:0] K_STB  = 3'b100;
   localparam logic [2:0] K_DONE = 3'b010;
   localparam logic [2:0] K_CFG  = 3'b001;

   typedef struct {
      int         cyc;
      logic [2:0] kind;
      logic [7:0] ph;
      logic [7:0] idx;
      int         busy_n;
      int         tone_n;
   } ev_t;

   ev_t sb[$];
   ev_t e;
   int  cyc = 0;
   int  total = 0;
   int  bad = 0;
   int  busy_cnt = 0;
   int  tone_cnt = 0;
   logic [2:0] kind;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
      end
   endtask

   function automatic void exp_ev(input int c, input logic [2:0] k, input logic [7:0] ph,
                                  input logic [7:0] idx, input int bn, input int tn);
      ev_t x;
      x.cyc = c; x.kind = k; x.ph = ph; x.idx = idx; x.busy_n = bn; x.tone_n = tn;
      sb.push_back(x);
   endfunction

   // Busy/tone cycles are tallied between terminal events so each done/cfg_err
   // event also checks how long the sweep occupied the block.
   always @(negedge clk) begin
      if (rst) begin
         busy_cnt = 0;
         tone_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (tone_en) tone_cnt++;
         kind = {step_strobe, done, cfg_err};
         if (kind != 3'b000) begin
            if (sb.size() == 0) begin
               chk("unexpected_event", int'(kind), 0);
            end else begin
               e = sb.pop_front();
               chk("ev_cycle", cyc, e.cyc);
               chk("ev_kind", int'(kind), int'(e.kind));
               chk("ev_phase_inc", int'(phase_inc), int'(e.ph));
               chk("ev_step_idx", int'(step_idx), int'(e.idx));
               if (e.busy_n >= 0) begin
                  chk("ev_busy_cycles", busy_cnt, e.busy_n);
                  chk("ev_tone_cycles", tone_cnt, e.tone_n);
                  busy_cnt = 0;
                  tone_cnt = 0;
               end
            end
         end
      end
   end

   // Call at posedge+1; returns at posedge+1 of the accepting edge with s = that cycle.
   task automatic do_start(input logic [7:0] fs, input logic [7:0] fst, input logic [7:0] fsp,
                           input logic [15:0] dw, input logic [7:0] gl, output int s);
      f_start = fs; f_step = fst; f_stop = fsp; dwell = dw; gap_len = gl;
      start = 1'b1;
      @(posedge clk); #1;
      s = cyc;
      start = 1'b0;
      f_start = 8'hAA; f_step = 8'h55; f_stop = 8'h0F; dwell = 16'd7; gap_len = 8'd9;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_reached", int'(busy), 0);
      @(posedge clk); #1;
   endtask

   task automatic step_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int last_idx;
      logic [5:0] pat;

      step_cycles(3);
      chk("reset_outputs", int'({phase_inc, tone_en, step_strobe, step_idx, busy, done, cfg_err}), 0);

      rst = 1'b0;
`ifndef DAC_SWEEP_GAP_EN
      // basic 3-step sweep, start on the first edge after reset release
      do_start(8'd1, 8'd1, 8'd3, 16'd4, 8'd5, s);
      chk("settle_phase_inc", int'(phase_inc), 1);
      chk("settle_tone_en", int'(tone_en), 0);
      exp_ev(s + 6,  K_STB,  8'd2, 8'd1, -1, -1);
      exp_ev(s + 10, K_STB,  8'd3, 8'd2, -1, -1);
      exp_ev(s + 14, K_DONE, 8'd0, 8'd2, 15, 12);
      wait_idle();
      last_idx = 2;
`else
      // gap build: RUN x2, GAP x2, RUN x2
      do_start(8'd1, 8'd1, 8'd2, 16'd2, 8'd2, s);
      exp_ev(s + 4, K_STB,  8'd2, 8'd1, -1, -1);
      exp_ev(s + 8, K_DONE, 8'd0, 8'd1, 9, 4);
      pat = 6'd0;
      for (int i = 1; i <= 7; i++) begin
         @(posedge clk); #1;
         if (cyc >= s + 2) pat = {pat[4:0], tone_en};
      end
      chk("gap_tone_pattern", int'(pat), int'(6'b110011));
      wait_idle();
      last_idx = 1;
`endif

      // rejected configurations
      do_start(8'd1, 8'd0, 8'd5, 16'd2, 8'd0, s);
      exp_ev(s, K_CFG, 8'd0, last_idx[7:0], 0, 0);
      wait_idle();
      do_start(8'd9, 8'd1, 8'd8, 16'd2, 8'd0, s);
      exp_ev(s, K_CFG, 8'd0, last_idx[7:0], 0, 0);
      wait_idle();

      // start with stop is ignored
      stop = 1'b1;
      do_start(8'd1, 8'd1, 8'd5, 16'd2, 8'd0, s);
      stop = 1'b0;
      chk("startstop_busy", int'(busy), 0);
      chk("startstop_cfg_err", int'(cfg_err), 0);
      step_cycles(2);

`ifndef DAC_SWEEP_GAP_EN
      // overflowing sum ends the sweep without a step
      do_start(8'd200, 8'd100, 8'd255, 16'd3, 8'd0, s);
      exp_ev(s + 5, K_DONE, 8'd0, 8'd0, 6, 3);
      step_cycles(3);
      chk("nowrap_phase_inc", int'(phase_inc), 200);
      wait_idle();

      // stop coincident with terminal count wins over the step
      do_start(8'd1, 8'd1, 8'd10, 16'd2, 8'd0, s);
      exp_ev(s + 4, K_DONE, 8'd0, 8'd0, 5, 2);
      step_cycles(3);
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      wait_idle();
`endif

      // reset mid-RUN then immediate restart
      do_start(8'd1, 8'd1, 8'd10, 16'd4, 8'd0, s);
      step_cycles(3);
      chk("midrun_tone_en", int'(tone_en), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrun_rst_outputs", int'({phase_inc, tone_en, step_strobe, step_idx, busy, done, cfg_err}), 0);
      rst = 1'b0;
      do_start(8'd1, 8'd1, 8'd1, 16'd1, 8'd0, s);
      chk("restart_busy", int'(busy), 1);
      exp_ev(s + 3, K_DONE, 8'd0, 8'd0, 4, 1);
      wait_idle();

      step_cycles(2);
      chk("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dac_sweep_ctrl.md
DAC_SWEEP_CTRL -- requirements
Module: dac_sweep_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: port clk (input, 1, rising-edge clock) and port rst (input, 1, synchronous active-high reset).
REQ-002 start  input  1  request sweep; sampled only in IDLE.
REQ-003 stop  input  1  abort request; honoured in any non-IDLE state.
REQ-004 f_start  input  8  first phase increment.
REQ-005 f_step  input  8  increment added per step.
REQ-006 f_stop  input  8  last permitted phase increment.
REQ-007 dwell  input  16  clk cycles per step.
REQ-008 gap_len  input  8  silent cycles between steps (used only with DAC_SWEEP_GAP_EN).
REQ-009 phase_inc  output  8  phase increment driven to the DDS phase counter.
REQ-010 tone_en  output  1  high when DAC codes are valid; the DAC data path is gated by it.
REQ-011 step_strobe  output  1  one-cycle pulse on each increment change.
REQ-012 step_idx  output  8  steps completed since start, saturating at 255.
REQ-013 busy  output  1  high in any non-IDLE state.
REQ-014 done  output  1  one-cycle pulse when a sweep ends (normal or aborted).
REQ-015 cfg_err  output  1  one-cycle pulse when start is rejected.

Function
REQ-016 States SHALL be IDLE, SETTLE, RUN, GAP and DONE, encoded in a registered FSM.
REQ-017 In IDLE with start=1 and stop=0, the block SHALL latch f_start, f_step, f_stop, dwell and gap_len into shadow registers; later input changes have no effect until the next start.
REQ-018 A start with f_step=0 or f_start>f_stop SHALL be rejected: cfg_err=1 for 1 cycle, FSM stays in IDLE, other outputs unchanged.
REQ-019 An accepted start SHALL enter SETTLE with phase_inc=f_start, tone_en=0 and step_idx=0.
REQ-020 SETTLE SHALL last exactly 2 cycles (DDS pipeline latency), then go to RUN with tone_en=1.
REQ-021 RUN SHALL hold phase_inc for max(dwell,1) cycles; dwell=0 is treated as 1.
REQ-022 At the dwell terminal count, the 9-bit sum phase_inc+f_step SHALL be compared with f_stop.
  - If the sum > f_stop: go to DONE.
  - Otherwise: phase_inc <= the sum, step_strobe=1 for that cycle, step_idx increments, dwell counter reloads.
  - No 8-bit wrap is permitted.
REQ-023 Without the gap feature, RUN SHALL continue directly into the next step with no dead cycle.
REQ-024 DONE SHALL last 1 cycle with done=1, tone_en=0 and phase_inc=0, then return to IDLE.
REQ-025 stop=1 in SETTLE, RUN or GAP SHALL move the FSM to DONE on the next edge; stop has priority over a coincident step terminal count.
REQ-026 start while busy=1 SHALL be ignored; start and stop asserted together in IDLE SHALL be ignored.
REQ-027 step_strobe, done and cfg_err SHALL never assert in the same cycle.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE and clear every output and internal counter to 0, including when asserted mid-sweep.
REQ-029 rst SHALL have priority over start and stop.
REQ-030 The first start SHALL be accepted on the first edge after rst deasserts.

Configuration
REQ-031 Macro DAC_SWEEP_GAP_EN, when defined, SHALL compile in the GAP state:
  - Each accepted step goes RUN -> GAP for max(gap_len,1) cycles with tone_en=0 and phase_inc already updated, then returns to RUN.
  - step_strobe fires on entry to GAP.
REQ-032 When DAC_SWEEP_GAP_EN is undefined, the GAP state, the gap counter and the gap_len logic SHALL be absent, gap_len SHALL be ignored, and REQ-023 SHALL apply.

Verification
REQ-033 Stimulus: f_start=1, f_step=1, f_stop=3, dwell=4, pulse start -> phase_inc 1,2,3 for 4 RUN cycles each; 2 step_strobes; step_idx=2; done 1 cycle after the last dwell; busy high for 2+12+1 cycles.
REQ-034 Stimulus: f_step=0, or f_start=9 with f_stop=8 -> cfg_err pulse, busy stays 0.
REQ-035 Stimulus: f_start=200, f_step=100, f_stop=255, dwell=3 -> no step (sum 300 > 255), done after 3 RUN cycles, phase_inc never wraps to 44.
REQ-036 Stimulus: stop asserted in cycle 2 of RUN, coincident with the terminal count -> DONE next edge, no step_strobe.
REQ-037 Stimulus: rst asserted mid-RUN -> all outputs 0 next edge; a new start is accepted immediately after.
REQ-038 With DAC_SWEEP_GAP_EN defined, gap_len=2, f_start=1, f_step=1, f_stop=2, dwell=2 -> tone_en pattern 1,1,0,0,1,1 across RUN/GAP/RUN.
